// File: rtl/prod_accum_if.sv
// Handshake bundle between the multiplier-side producer, prod_accum and the frame consumer.
// Input side is a valid/ready product stream; output side is a valid/ready frame result.
interface prod_accum_if #(
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       prod;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;
    logic [7:0]       cnt;

    modport master (
        output in_valid, prod, out_ready,
        input  in_ready, out_valid, acc_out, ovf, cnt
    );

    modport slave (
        input  in_valid, prod, out_ready,
        output in_ready, out_valid, acc_out, ovf, cnt
    );
endinterface

// File: rtl/prod_accum.sv
// Sums LEN unsigned 8-bit products per frame; presents the result with a sticky overflow flag.
// Latency: result valid 1 cycle after the last accepted product; no comb path prod -> acc_out.
// Backpressure: in_ready drops while a frame result waits for out_ready; clr discards everything.
module prod_accum #(
    parameter int LEN   = 8,
    parameter int ACC_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    prod_accum_if.slave   bus
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic             ovf, ovf_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [ACC_W:0]   sum;

    // One spare bit on top of the accumulator captures the carry-out of this add.
    assign sum = {1'b0, acc} + {{(ACC_W-7){1'b0}}, bus.prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            ovf   <= ovf_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        cnt_nxt   = cnt;
        if (clr) begin
            state_nxt = ACC;
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ACC: begin
                    if (bus.in_valid) begin
                        acc_nxt = sum[ACC_W-1:0];
                        ovf_nxt = ovf | sum[ACC_W];
                        cnt_nxt = cnt + 8'd1;
                        if (cnt == 8'(LEN - 1)) begin
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_nxt = ACC;
                        acc_nxt   = '0;
                        ovf_nxt   = 1'b0;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = ACC;
                end
            endcase
        end
    end

    // Handshake outputs depend on state only, so neither ready nor valid loops back combinationally.
    assign bus.in_ready  = (state == ACC);
    assign bus.out_valid = (state == HOLD);
    assign bus.acc_out   = acc;
    assign bus.ovf       = ovf;
    assign bus.cnt       = cnt;

endmodule

// File: tb/tb_prod_accum.sv
// Drives three prod_accum configurations (LEN/ACC_W = 4/16, 8/16, 8/10) with shared stimulus and
// checks every cycle against a frame-sum model built from running totals.
module tb_prod_accum;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic [7:0] prod;
    logic       out_ready;

    prod_accum_if #(.ACC_W(16)) if_a ();
    prod_accum_if #(.ACC_W(16)) if_b ();
    prod_accum_if #(.ACC_W(10)) if_c ();

    prod_accum #(.LEN(4), .ACC_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if_a));
    prod_accum #(.LEN(8), .ACC_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if_b));
    prod_accum #(.LEN(8), .ACC_W(10)) dut_c (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if_c));

    assign if_a.in_valid = in_valid;
    assign if_a.prod = prod;
    assign if_a.out_ready = out_ready;
    assign if_b.in_valid = in_valid;
    assign if_b.prod = prod;
    assign if_b.out_ready = out_ready;
    assign if_c.in_valid = in_valid;
    assign if_c.prod = prod;
    assign if_c.out_ready = out_ready;

    logic        ir_o  [3];
    logic        ov_o  [3];
    logic        ovf_o [3];
    logic [7:0]  cnt_o [3];
    logic [31:0] acc_o [3];

    assign ir_o[0] = if_a.in_ready;
    assign ir_o[1] = if_b.in_ready;
    assign ir_o[2] = if_c.in_ready;
    assign ov_o[0] = if_a.out_valid;
    assign ov_o[1] = if_b.out_valid;
    assign ov_o[2] = if_c.out_valid;
    assign ovf_o[0] = if_a.ovf;
    assign ovf_o[1] = if_b.ovf;
    assign ovf_o[2] = if_c.ovf;
    assign cnt_o[0] = if_a.cnt;
    assign cnt_o[1] = if_b.cnt;
    assign cnt_o[2] = if_c.cnt;
    assign acc_o[0] = {16'd0, if_a.acc_out};
    assign acc_o[1] = {16'd0, if_b.acc_out};
    assign acc_o[2] = {22'd0, if_c.acc_out};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference: a frame is just a running total and a product count per instance.
    longint sum_m  [3];
    int     cnt_m  [3];
    bit     full_m [3];

    function automatic int len_of(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic int w_of(input int i);
        return (i == 2) ? 10 : 16;
    endfunction

    task automatic model_clear(input int i);
        sum_m[i]  = 0;
        cnt_m[i]  = 0;
        full_m[i] = 1'b0;
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (!rst_n || clr) begin
                model_clear(i);
            end else if (full_m[i]) begin
                if (out_ready) model_clear(i);
            end else if (in_valid) begin
                sum_m[i] += longint'(prod);
                cnt_m[i] += 1;
                if (cnt_m[i] == len_of(i)) full_m[i] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    task automatic check_all();
        longint modv;
        for (int i = 0; i < 3; i++) begin
            modv = longint'(1) << w_of(i);
            chk("in_ready", i, 64'(ir_o[i]), 64'(!full_m[i]));
            chk("out_valid", i, 64'(ov_o[i]), 64'(full_m[i]));
            chk("cnt", i, 64'(cnt_o[i]), 64'(cnt_m[i]));
            chk("acc_out", i, 64'(acc_o[i]), 64'(sum_m[i] % modv));
            chk("ovf", i, 64'(ovf_o[i]), 64'(sum_m[i] >= modv));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic iv, input logic [7:0] p, input logic ordy, input logic c);
        in_valid  = iv;
        prod      = p;
        out_ready = ordy;
        clr       = c;
        tick();
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_out_valid"}, i, 64'(ov_o[i]), 64'd0);
            chk({tag, "_cnt"}, i, 64'(cnt_o[i]), 64'd0);
            chk({tag, "_acc"}, i, 64'(acc_o[i]), 64'd0);
            chk({tag, "_ovf"}, i, 64'(ovf_o[i]), 64'd0);
        end
    endtask

    logic [7:0] gap_p [4];

    initial begin
        rst_n = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        prod = 8'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) model_clear(i);
        gap_p[0] = 8'd10;
        gap_p[1] = 8'd0;
        gap_p[2] = 8'd200;
        gap_p[3] = 8'd15;

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        #2 rst_n = 1'b1;
        tick();

        // Basic frame on the LEN=4 instance.
        drive(1'b0, 8'd0, 1'b1, 1'b1);
        repeat (4) drive(1'b1, 8'd225, 1'b1, 1'b0);
        chk("basic_valid", 0, 64'(ov_o[0]), 64'd1);
        chk("basic_acc", 0, 64'(acc_o[0]), 64'd900);
        chk("basic_ovf", 0, 64'(ovf_o[0]), 64'd0);
        chk("basic_rdy_low", 0, 64'(ir_o[0]), 64'd0);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        chk("basic_rdy_back", 0, 64'(ir_o[0]), 64'd1);

        // Backpressure on the LEN=8 instance with a pending product held upstream.
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) drive(1'b1, 8'(k), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'd99, 1'b0, 1'b0);
            chk("bp_acc", 1, 64'(acc_o[1]), 64'd36);
            chk("bp_rdy", 1, 64'(ir_o[1]), 64'd0);
        end
        drive(1'b1, 8'd99, 1'b1, 1'b0);
        drive(1'b1, 8'd99, 1'b0, 1'b0);
        chk("bp_next_cnt", 1, 64'(cnt_o[1]), 64'd1);
        chk("bp_next_acc", 1, 64'(acc_o[1]), 64'd99);

        // Overflow on the ACC_W=10 instance, then a clean frame.
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        repeat (8) drive(1'b1, 8'd225, 1'b0, 1'b0);
        chk("ovf_acc", 2, 64'(acc_o[2]), 64'd776);
        chk("ovf_flag", 2, 64'(ovf_o[2]), 64'd1);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        repeat (8) drive(1'b1, 8'd1, 1'b0, 1'b0);
        chk("ovf2_acc", 2, 64'(acc_o[2]), 64'd8);
        chk("ovf2_flag", 2, 64'(ovf_o[2]), 64'd0);

        // Gapped input on the LEN=4 instance.
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, gap_p[k], 1'b0, 1'b0);
            repeat (3) drive(1'b0, 8'hAA, 1'b0, 1'b0);
            chk("gap_cnt", 0, 64'(cnt_o[0]), 64'(k + 1));
        end
        chk("gap_acc", 0, 64'(acc_o[0]), 64'd225);

        // clr mid-frame, then clr while holding a result.
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        repeat (3) drive(1'b1, 8'd7, 1'b0, 1'b0);
        drive(1'b1, 8'd50, 1'b0, 1'b1);
        chk("clr_cnt", 1, 64'(cnt_o[1]), 64'd0);
        chk("clr_acc", 1, 64'(acc_o[1]), 64'd0);
        repeat (8) drive(1'b1, 8'd2, 1'b0, 1'b0);
        chk("clr_frame_acc", 1, 64'(acc_o[1]), 64'd16);
        drive(1'b0, 8'd0, 1'b1, 1'b1);
        chk("clr_hold_valid", 1, 64'(ov_o[1]), 64'd0);

        // Asynchronous reset mid-frame, between clock edges.
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        repeat (5) drive(1'b1, 8'd3, 1'b0, 1'b0);
        chk("arst_pre_cnt", 1, 64'(cnt_o[1]), 64'd5);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) model_clear(i);
        #1;
        check_zero("arst");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (8) drive(1'b1, 8'd3, 1'b0, 1'b0);
        chk("arst_frame_acc", 1, 64'(acc_o[1]), 64'd24);

        // Random traffic with occasional clears; 225 is favoured to exercise overflow.
        for (int k = 0; k < 400; k++) begin
            drive(1'b1 && ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0) ? 8'd225 : 8'($urandom_range(0, 225)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Sequential accumulation stage directly downstream of the 4x4 unsigned Dadda multiplier.
- Consumes the 8-bit product {Cout, Z[6:0]} one sample per accepted handshake and sums LEN consecutive products into a frame result.
- Presents the frame result on a valid/ready output port with a sticky overflow flag.
- Together with the multiplier it forms a small dot-product / MAC datapath.

Parameters:
- LEN, 8, number of products summed per frame; legal range 2..255.
- ACC_W, 16, accumulator and result width in bits; legal range 8..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous frame abort/clear.
- in_valid  input  1  prod is valid this cycle.
- in_ready  output  1  block can accept prod this cycle.
- prod  input  8  multiplier product, prod = {Cout, Z}, unsigned, 0..225.
- out_valid  output  1  acc_out and ovf hold a completed frame.
- out_ready  input  1  downstream accepts the frame.
- acc_out  output  ACC_W  sum of LEN products, modulo 2^ACC_W.
- ovf  output  1  a carry out of bit ACC_W-1 occurred during this frame.
- cnt  output  8  number of products accepted in the current frame.

Behaviour:
- Reset (rst_n low, asynchronous, any cycle):
  - state=ACC; acc=0, cnt=0, ovf=0, out_valid=0.
  - in_ready=1 from the first clock after rst_n deasserts.
- Two-state FSM: ACC (collecting) and HOLD (result presented).
- ACC state:
  - in_ready=1 and out_valid=0.
  - A product is accepted on a rising edge with in_valid && in_ready.
  - On accept: acc <= acc + zero-extended prod, truncated to ACC_W. ovf <= ovf | carry-out. cnt <= cnt+1.
  - On the accept where cnt==LEN-1: the final sum is loaded into acc_out, out_valid <= 1, state <= HOLD, cnt <= LEN.
  - Latency from the last accepted product to out_valid is 1 cycle. There is no combinational path from prod to acc_out.
- HOLD state:
  - in_ready=0 and out_valid=1.
  - acc_out, ovf and cnt are held stable until transfer, regardless of in_valid.
  - Transfer occurs on a rising edge with out_valid && out_ready. On transfer: acc, cnt, ovf <= 0; out_valid <= 0; state <= ACC.
  - in_ready returns to 1 on the cycle after transfer. There is no same-cycle input bypass.
- in_valid while in_ready=0: the product is not consumed. The upstream holds it. The block never drops or double-counts a product.
- in_ready and out_valid are pure functions of state (registered) and never depend combinationally on in_valid or out_ready.
- clr:
  - Synchronous. Highest priority after reset.
  - In either state it sets acc, cnt, ovf = 0, out_valid = 0, state = ACC.
  - A product presented in the same cycle as clr is discarded (not accepted).
  - A pending HOLD result is discarded and is not transferred even if out_ready=1.
- Overflow:
  - Wrap-around arithmetic modulo 2^ACC_W.
  - ovf is sticky within a frame and is cleared only by transfer, clr or reset.
  - With LEN=8 and ACC_W>=11 ovf can never assert (max 1800).
- acc_out:
  - Outside HOLD, acc_out shows the running accumulator, for debug only.
  - Downstream samples it only when out_valid=1.
- in_valid gaps: cnt and acc hold. There is no timeout.
- Reset mid-frame: partial sum is lost; the next frame restarts from cnt=0.

Test Plan:
- Basic frame: LEN=4, ACC_W=16, prod=225 on 4 back-to-back cycles, out_ready=1 -> out_valid high exactly 1 cycle after 4th accept; acc_out=900 (0x0384); ovf=0; in_ready low 1 cycle then high.
- Backpressure: LEN=8, prods 1..8, out_ready=0 for 5 cycles after out_valid, in_valid held high with prod=99 -> acc_out=36 stable for all 5 cycles; in_ready=0; no product accepted. After out_ready=1 transfer, the next frame starts with 99 as its first product, cnt=1.
- Overflow: LEN=8, ACC_W=10, prod=225 x8 -> acc_out=776 (1800-1024); ovf=1. Next frame with prod=1 x8 -> acc_out=8, ovf=0.
- Gapped input: LEN=4, prods 10,0,200,15 with in_valid deasserted 3 cycles between each -> acc_out=225; cnt steps 1,2,3 then 4; no extra accepts during gaps.
- clr: LEN=8, accept 3 products, then assert clr together with in_valid (prod=50) -> cnt=0, acc=0. Next 8 products of 2 -> acc_out=16. clr asserted in HOLD with out_ready=1 -> no transfer, out_valid=0 next cycle.
- Async reset: drop rst_n mid-frame (cnt=5) between clock edges -> out_valid, cnt, acc_out, ovf go 0 immediately without a clock edge. After release, a full frame of prod=3 (LEN=8) -> acc_out=24.
